// File: rtl/tach_pkg.sv
// Shared defaults, gate-length helper and the saturating step used by every tachometer channel.
package tach_pkg;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_CLOCK_FREQ  = 100000000;
  localparam int DEF_GATE_HZ     = 1000;
  localparam int DEF_COUNT_W     = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef logic [DEF_COUNT_W-1:0] count_t;

  typedef struct packed {
    logic        sat;
    logic [31:0] value;
  } sat_res_t;

  function automatic int unsigned gate_clks(input int unsigned clock_freq,
                                            input int unsigned gate_hz);
    return clock_freq / gate_hz;
  endfunction

  // One counting step on a width-bit accumulator (width <= 32); sat flags a count that was lost.
  function automatic sat_res_t sat_step(input logic [31:0] acc,
                                        input logic        inc,
                                        input logic        down,
                                        input int unsigned width,
                                        input logic        is_signed);
    logic [31:0] mask;
    logic [31:0] max_v;
    logic [31:0] min_v;
    sat_res_t    r;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    if (is_signed) begin
      max_v = (32'd1 << (width - 1)) - 32'd1;
      min_v = 32'd1 << (width - 1);
    end else begin
      max_v = mask;
      min_v = '0;
    end
    r.sat   = 1'b0;
    r.value = acc & mask;
    if (inc) begin
      if (!down) begin
        if (r.value == max_v) r.sat = 1'b1;
        else                  r.value = (r.value + 32'd1) & mask;
      end else begin
        if (r.value == min_v) r.sat = 1'b1;
        else                  r.value = (r.value - 32'd1) & mask;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tachometer_mc_channel.sv
// One encoder channel: synchroniser, rising-edge detector, saturating accumulator, output latch.
// TACH_DIR_EN adds the quadrature B input and switches to signed up/down counting.
module tach_channel
  import tach_pkg::*;
#(
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               enable,
  input  logic               clear,
  input  logic               publish,
  input  logic               encoder_a,
`ifdef TACH_DIR_EN
  input  logic               encoder_b,
`endif
  output logic [COUNT_W-1:0] count_out,
  output logic               overflow
);

  typedef logic [COUNT_W-1:0] cnt_t;

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic                   hist_q, hist_d;
  cnt_t                   acc_q, acc_d;
  logic                   sticky_q, sticky_d;
  cnt_t                   count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_det;
  logic                   down;
  sat_res_t               step;

`ifdef TACH_DIR_EN
  localparam logic SIGNED_MODE = 1'b1;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;

  always_comb begin
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], encoder_b};
    down     = sync_b_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (srst) sync_b_q <= '0;
    else      sync_b_q <= sync_b_d;
  end
`else
  localparam logic SIGNED_MODE = 1'b0;
  assign down = 1'b0;
`endif

  assign edge_det = sync_a_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], encoder_a};
    hist_d   = sync_a_q[SYNC_STAGES-1];
    step     = sat_step(32'(acc_q), edge_det, down, COUNT_W, SIGNED_MODE);
    acc_d    = acc_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (publish) begin
      // An edge landing on the terminal cycle belongs to the window being closed.
      count_d  = COUNT_W'(step.value);
      ovf_d    = sticky_q | step.sat;
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (enable) begin
      acc_d    = COUNT_W'(step.value);
      sticky_d = sticky_q | step.sat;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_a_q <= '0;
      hist_q   <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync_a_q <= sync_a_d;
      hist_q   <= hist_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count_out = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/tachometer_mc.sv
// Multi-channel encoder tachometer: gate counter, publish strobe and NUM_CH channel instances.
// Define TACH_DIR_EN for the encoder_b port and signed quadrature counting.
module tachometer_mc
  import tach_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CLOCK_FREQ  = DEF_CLOCK_FREQ,
  parameter int GATE_HZ     = DEF_GATE_HZ,
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      clock,
  input  logic                      system_reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         encoder_in,
`ifdef TACH_DIR_EN
  input  logic [NUM_CH-1:0]         encoder_b,
`endif
  output logic [NUM_CH*COUNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]         overflow,
  output logic                      sample_valid
);

  localparam int unsigned GATE_CLKS = gate_clks(CLOCK_FREQ, GATE_HZ);
  localparam int          GATE_W    = $clog2(GATE_CLKS);

  logic [GATE_W-1:0] gate_q, gate_d;
  logic              valid_q, valid_d;
  logic              terminal;

  assign terminal = enable && (gate_q == GATE_W'(GATE_CLKS - 1));

  always_comb begin
    gate_d  = gate_q + GATE_W'(1);
    valid_d = terminal;
    if (!enable || terminal) gate_d = '0;
  end

  always_ff @(posedge clock) begin
    if (system_reset) begin
      gate_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      gate_q  <= gate_d;
      valid_q <= valid_d;
    end
  end

  assign sample_valid = valid_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    tach_channel #(
      .COUNT_W     (COUNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (clock),
      .srst      (system_reset),
      .enable    (enable),
      .clear     (~enable),
      .publish   (terminal),
      .encoder_a (encoder_in[gi]),
`ifdef TACH_DIR_EN
      .encoder_b (encoder_b[gi]),
`endif
      .count_out (count_out[gi*COUNT_W +: COUNT_W]),
      .overflow  (overflow[gi])
    );
  end

endmodule

// File: tb/tb_tachometer_mc.sv
// Bench for tachometer_mc: 8-bit and 4-bit instances share stimulus, checked against a window-level model.
module tb_tachometer_mc;

  localparam int G = 100;
  localparam int S = 2;
`ifdef TACH_DIR_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  enc, encb;
  logic [15:0] c8;
  logic [7:0]  c4;
  logic [1:0]  ov8, ov4;
  logic        v8, v4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tachometer_mc #(.NUM_CH(2), .CLOCK_FREQ(1000), .GATE_HZ(10), .COUNT_W(8), .SYNC_STAGES(S)) dut8 (
    .clock(clk), .system_reset(rst), .enable(en), .encoder_in(enc),
`ifdef TACH_DIR_EN
    .encoder_b(encb),
`endif
    .count_out(c8), .overflow(ov8), .sample_valid(v8));

  tachometer_mc #(.NUM_CH(2), .CLOCK_FREQ(1000), .GATE_HZ(10), .COUNT_W(4), .SYNC_STAGES(S)) dut4 (
    .clock(clk), .system_reset(rst), .enable(en), .encoder_in(enc),
`ifdef TACH_DIR_EN
    .encoder_b(encb),
`endif
    .count_out(c4), .overflow(ov4), .sample_valid(v4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lim_hi(input int w);
    return SGN ? (1 << (w - 1)) - 1 : (1 << w) - 1;
  endfunction
  function automatic int lim_lo(input int w);
    return SGN ? -(1 << (w - 1)) : 0;
  endfunction

  // sa[c][d]: pin value seen d+1 clock edges ago (zero after reset)
  bit sa[2][S+1];
  bit sb[2][S+1];
  int m_acc[2][2];
  bit m_stk[2][2];
  int m_cnt[2][2];
  bit m_ov[2][2];
  bit m_vld;
  int m_win;
  bit model_on = 1'b0;
  int wid[2] = '{8, 4};

  always @(posedge clk) begin : model
    bit rise[2];
    int dlt[2];
    bit close;
    int nv;
    bit o;
    for (int c = 0; c < 2; c++) begin
      rise[c] = sa[c][S-1] && !sa[c][S];
      dlt[c]  = (SGN && sb[c][S-1]) ? -1 : 1;
    end
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k <= S; k++) begin sa[c][k] = 1'b0; sb[c][k] = 1'b0; end
        for (int d = 0; d < 2; d++) begin
          m_acc[d][c] = 0; m_stk[d][c] = 1'b0; m_cnt[d][c] = 0; m_ov[d][c] = 1'b0;
        end
      end
      m_vld = 1'b0;
      m_win = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int k = S; k > 0; k--) begin sa[c][k] = sa[c][k-1]; sb[c][k] = sb[c][k-1]; end
        sa[c][0] = enc[c];
        sb[c][0] = encb[c];
      end
      if (!en) begin
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 2; c++) begin m_acc[d][c] = 0; m_stk[d][c] = 1'b0; end
        m_vld = 1'b0;
        m_win = 0;
      end else begin
        m_win++;
        close = (m_win == G);
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 2; c++) begin
            nv = m_acc[d][c] + (rise[c] ? dlt[c] : 0);
            o  = 1'b0;
            if (nv > lim_hi(wid[d])) begin nv = lim_hi(wid[d]); o = 1'b1; end
            if (nv < lim_lo(wid[d])) begin nv = lim_lo(wid[d]); o = 1'b1; end
            if (close) begin
              m_cnt[d][c] = nv; m_ov[d][c] = m_stk[d][c] | o;
              m_acc[d][c] = 0;  m_stk[d][c] = 1'b0;
            end else begin
              m_acc[d][c] = nv; m_stk[d][c] = m_stk[d][c] | o;
            end
          end
        m_vld = close;
        if (close) m_win = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_valid8", 32'(v8), 32'(m_vld));
      check("model_valid4", 32'(v4), 32'(m_vld));
      for (int c = 0; c < 2; c++) begin
        check($sformatf("model_cnt8_ch%0d", c), 32'(c8[c*8 +: 8]), 32'(m_cnt[0][c] & 255));
        check($sformatf("model_cnt4_ch%0d", c), 32'(c4[c*4 +: 4]), 32'(m_cnt[1][c] & 15));
        check($sformatf("model_ovf8_ch%0d", c), 32'(ov8[c]), 32'(m_ov[0][c]));
        check($sformatf("model_ovf4_ch%0d", c), 32'(ov4[c]), 32'(m_ov[1][c]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic bit pulse(input int cyc, input int n);
    return (cyc >= 4) && (cyc < 4 + 2 * n) && (cyc % 2 == 0);
  endfunction

  // Drive one window from a negedge; k = posedges until sample_valid seen (200 if never).
  task automatic win(input int n0, input int n1, input bit late, input logic [1:0] b, output int k);
    k = 200;
    for (int cyc = 0; cyc < 200; cyc++) begin
      en     = 1'b1;
      enc[0] = pulse(cyc, n0) || (late && cyc == 97);
      enc[1] = pulse(cyc, n1);
      encb   = b;
      @(posedge clk);
      @(negedge clk);
      if (v8) begin k = cyc + 1; break; end
    end
    enc = 2'b00;
  endtask

  typedef struct {
    int         n0, n1;
    bit         late;
    logic [7:0] c0_8, c1_8;
    logic [3:0] c0_4, c1_4;
    logic [1:0] ov8, ov4;
  } vec_t;

  vec_t tv[7];

  initial begin
    int k;
    logic [15:0] held8;
    logic [7:0]  held4;

    tv[0] = '{5,  0, 1'b0, 8'd5,  8'd0,  4'd5,  4'd0,  2'b00, 2'b00};
`ifdef TACH_DIR_EN
    tv[1] = '{45, 3, 1'b0, 8'd45, 8'd3,  4'd7,  4'd3,  2'b00, 2'b01};
    tv[3] = '{16, 15, 1'b0, 8'd16, 8'd15, 4'd7, 4'd7,  2'b00, 2'b11};
`else
    tv[1] = '{45, 3, 1'b0, 8'd45, 8'd3,  4'd15, 4'd3,  2'b00, 2'b01};
    tv[3] = '{16, 15, 1'b0, 8'd16, 8'd15, 4'd15, 4'd15, 2'b00, 2'b01};
`endif
    tv[2] = '{0,  0, 1'b0, 8'd0,  8'd0,  4'd0,  4'd0,  2'b00, 2'b00};
    tv[4] = '{0,  0, 1'b1, 8'd1,  8'd0,  4'd1,  4'd0,  2'b00, 2'b00};
    tv[5] = '{0,  0, 1'b0, 8'd0,  8'd0,  4'd0,  4'd0,  2'b00, 2'b00};
    tv[6] = '{7,  2, 1'b0, 8'd7,  8'd2,  4'd7,  4'd2,  2'b00, 2'b00};

    rst = 1'b1; en = 1'b0; enc = 2'b00; encb = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_on = 1'b1;
    check("reset_cnt8", 32'(c8), 32'd0);
    check("reset_cnt4", 32'(c4), 32'd0);
    check("reset_ovf8", 32'(ov8), 32'd0);
    check("reset_ovf4", 32'(ov4), 32'd0);
    check("reset_valid8", 32'(v8), 32'd0);
    check("reset_valid4", 32'(v4), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      win(tv[i].n0, tv[i].n1, tv[i].late, 2'b00, k);
      $display("window %0d: n0=%0d n1=%0d late=%0d -> latency=%0d cnt8=%0d/%0d cnt4=%0d/%0d ovf4=%b",
               i, tv[i].n0, tv[i].n1, tv[i].late, k, c8[7:0], c8[15:8], c4[3:0], c4[7:4], ov4);
      check($sformatf("tbl%0d_latency", i), 32'(k), 32'd100);
      check($sformatf("tbl%0d_cnt8_ch0", i), 32'(c8[7:0]), 32'(tv[i].c0_8));
      check($sformatf("tbl%0d_cnt8_ch1", i), 32'(c8[15:8]), 32'(tv[i].c1_8));
      check($sformatf("tbl%0d_cnt4_ch0", i), 32'(c4[3:0]), 32'(tv[i].c0_4));
      check($sformatf("tbl%0d_cnt4_ch1", i), 32'(c4[7:4]), 32'(tv[i].c1_4));
      check($sformatf("tbl%0d_ovf8", i), 32'(ov8), 32'(tv[i].ov8));
      check($sformatf("tbl%0d_ovf4", i), 32'(ov4), 32'(tv[i].ov4));
    end

    // enable gap mid-window: partial count discarded, outputs held, no strobe
    held8 = c8; held4 = c4;
    for (int cyc = 0; cyc < 40; cyc++) begin
      enc[0] = pulse(cyc, 3);
      @(posedge clk); @(negedge clk);
    end
    en = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      enc = (cyc < 25) ? 2'(cyc % 2) : 2'b00;
      @(posedge clk); @(negedge clk);
      check("gap_no_strobe", 32'(v8), 32'd0);
      check("gap_hold_cnt8", 32'(c8), 32'(held8));
      check("gap_hold_cnt4", 32'(c4), 32'(held4));
    end
    win(4, 0, 1'b0, 2'b00, k);
    $display("re-enable: latency=%0d cnt8_ch0=%0d", k, c8[7:0]);
    check("reenable_latency", 32'(k), 32'd100);
    check("reenable_cnt8_ch0", 32'(c8[7:0]), 32'd4);

    // reset mid-window with a partial count of 3
    for (int cyc = 0; cyc < 60; cyc++) begin
      enc[0] = pulse(cyc, 3);
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_cnt8", 32'(c8), 32'd0);
    check("midrst_cnt4", 32'(c4), 32'd0);
    check("midrst_valid", 32'(v8), 32'd0);
    check("midrst_ovf", 32'({ov8, ov4}), 32'd0);
    rst = 1'b0;
    win(2, 1, 1'b0, 2'b00, k);
    $display("after reset: latency=%0d cnt8=%0d/%0d", k, c8[7:0], c8[15:8]);
    check("postrst_latency", 32'(k), 32'd100);
    check("postrst_cnt8_ch0", 32'(c8[7:0]), 32'd2);
    check("postrst_cnt8_ch1", 32'(c8[15:8]), 32'd1);

`ifdef TACH_DIR_EN
    win(4, 0, 1'b0, 2'b01, k);
    $display("direction B=1: cnt8_ch0=0x%0h", c8[7:0]);
    check("dir_minus4", 32'(c8[7:0]), 32'h0000_00FC);
    win(4, 0, 1'b0, 2'b00, k);
    $display("direction B=0: cnt8_ch0=0x%0h", c8[7:0]);
    check("dir_plus4", 32'(c8[7:0]), 32'd4);
`endif

    // randomized traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      enc  = 2'($urandom_range(0, 3));
      encb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) en = ~en;
      rst = ($urandom_range(0, 1499) == 0);
      @(posedge clk); @(negedge clk);
      if (v8) $display("random strobe: cnt8=%0d/%0d cnt4=%0d/%0d ovf8=%b ovf4=%b",
                       c8[7:0], c8[15:8], c4[3:0], c4[7:4], ov8, ov4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tachometer_mc.md
Name: tachometer_mc

Overview:
- Multi-channel encoder tachometer: the next-generation parametrised speed-measurement block for the motor subsystem.
- Each of NUM_CH asynchronous encoder inputs is synchronised and rising-edge detected, then pulses are counted over a fixed gate window derived from the system clock.
- At the end of every window, all channel counts are published together with a one-cycle valid strobe and per-channel overflow flags.
- Output feeds the AXI/GPIO register interface read by the speed-control firmware.

Parameters:
- NUM_CH, 2, number of independent encoder channels (1..8).
- CLOCK_FREQ, 100000000, clock frequency in Hz.
- GATE_HZ, 1000, gate windows per second; GATE_CLKS = CLOCK_FREQ/GATE_HZ clocks per window (must be >= 4).
- COUNT_W, 16, width of each channel's pulse count.
- SYNC_STAGES, 2, synchroniser flops per encoder input (>= 2).

Ports:
- clock  in  1  system clock.
- system_reset  in  1  reset; one clock, reset is synchronous and active-high.
- enable  in  1  1 = measure; 0 = gate and accumulators held at zero.
- encoder_in  in  NUM_CH  raw asynchronous encoder A inputs, bit i = channel i.
- count_out  out  NUM_CH*COUNT_W  latched window counts, channel i at bits [i*COUNT_W +: COUNT_W].
- overflow  out  NUM_CH  channel i saturated during the last published window.
- sample_valid  out  1  one-cycle strobe: count_out/overflow updated this cycle.

Behaviour:
- Reset (system_reset=1 at a posedge): count_out=0, overflow=0, sample_valid=0, gate counter=0, accumulators=0, synchroniser and edge-history flops=0. Reset dominates enable and all inputs.
- Edge path: encoder_in[i] passes SYNC_STAGES flops, then one history flop. An edge is counted when sync=1 and hist=0.
  - A pin rise is counted into the accumulator SYNC_STAGES+1 clocks later.
  - Pulses narrower than one clock may be missed; this is not an error.
- Gate counter: counts 0..GATE_CLKS-1 while enable=1, then wraps to 0.
- Terminal cycle (gate == GATE_CLKS-1, enable=1), on the next edge:
  - count_out[i] <= acc[i] + edge[i], saturating at 2^COUNT_W-1;
  - overflow[i] <= (saturation occurred in this window);
  - acc[i] <= 0;
  - sample_valid <= 1 for exactly one cycle.
  - Publish latency is 1 clock after the terminal cycle. The period is exactly GATE_CLKS clocks.
- Simultaneous edge on the terminal cycle is counted in the closing window; none are lost or double-counted.
- Saturation: acc holds at all-ones. A sticky per-window overflow bit is set and cleared on publish.
- enable=0: gate and acc cleared every cycle; sync/history flops keep running; count_out/overflow hold; no sample_valid.
- enable rising: first window starts at gate=0; first sample_valid arrives GATE_CLKS clocks after enable is sampled high.
- Reset mid-window discards the partial count, and the next sample_valid follows a full window.

Optional Feature:
- TACH_DIR_EN defined: adds port encoder_b (in, NUM_CH), synchronised identically, for quadrature direction.
  - Each counted A edge adds +1 if synced B=0, or -1 if B=1.
  - acc and count_out are two's-complement signed COUNT_W, saturating at +2^(COUNT_W-1)-1 / -2^(COUNT_W-1).
  - Overflow is set on either limit.
- TACH_DIR_EN undefined: no encoder_b port; counts are unsigned up-only as above.

Decomposition:
- Package tach_pkg:
  - function gate_clks(CLOCK_FREQ, GATE_HZ);
  - localparam defaults;
  - typedef count_t (logic [COUNT_W-1:0], parametrised via the module);
  - saturate-add helper function.
- Sub-module tach_channel: one synchroniser, edge detector, saturating accumulator and output latch. Inputs: clear, publish, enable. Instantiated NUM_CH times in a generate loop.
- Top level owns the gate counter and sample_valid.

Test Plan:
- Use CLOCK_FREQ=1000, GATE_HZ=10 (GATE_CLKS=100), NUM_CH=2, COUNT_W=8. Reset for 3 clocks, enable=1, ch0 toggles every 10 clocks (5 rises/window), ch1 idle -> sample_valid every 100 clocks, first at clock 100 after enable; count_out ch0=5, ch1=0; overflow=0.
- Ch0 driven at clock/2 (50 rises/window), then COUNT_W=4 -> count_out ch0=50; with COUNT_W=4, count=15 and overflow[0]=1; next idle window -> 0 and overflow cleared.
- Edge timed to reach the detector exactly on gate==99 -> counted in the closing window; next window does not include it.
- enable dropped at gate=40 for 30 clocks, then raised -> no strobe during the gap; count_out holds; next strobe 100 clocks after re-enable.
- system_reset asserted for 1 clock at gate=60 with acc=3 -> all outputs 0 on the next cycle; next window counts from 0.
- TACH_DIR_EN: 4 A-rises with B=1 -> count_out = -4 (0xFC for COUNT_W=8); 4 with B=0 -> +4.
